// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: slot entry layout and
// forwarding-select width.
package hazard_pkg;

  localparam int unsigned DEFAULT_REG_AW = 5;
  // Slot fields are sized for the widest supported configuration.
  localparam int unsigned SLOT_RW_W = 16;
  localparam int unsigned SLOT_AV_W = 3;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [SLOT_RW_W-1:0] rw;
    logic [SLOT_AV_W-1:0] avail;
  } slot_t;

  function automatic int unsigned fw_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mul/div busy interlock: loads MD_LAT on issue and counts down to idle.
module md_busy_counter #(
  parameter int unsigned MD_LAT = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  output logic o_busy
);

  localparam int unsigned CW = $clog2(MD_LAT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(MD_LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes after ID and derives forwarding selects,
// load-use stall, flush bubble and the mul/div interlock.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = DEFAULT_REG_AW,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned ALU_AVAIL  = 2,
  parameter int unsigned LOAD_AVAIL = 3,
  parameter int unsigned MD_LAT     = 8,
  localparam int unsigned FW        = fw_width(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_ra,
  input  logic [REG_AW-1:0] i_rb,
  input  logic              i_ra_used,
  input  logic              i_rb_used,
  input  logic [REG_AW-1:0] i_rw,
  input  logic              i_we,
  input  logic              i_is_load,
  input  logic              i_is_md,
  input  logic              i_rd_hilo,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_bubble,
  output logic [FW-1:0]     o_fwd_a,
  output logic [FW-1:0]     o_fwd_b,
  output logic              o_md_busy
);

  slot_t r_slot [1:DEPTH];

  logic [DEPTH-1:1] w_match_a;
  logic [DEPTH-1:1] w_match_b;
  logic [FW-1:0]    w_fwd_a;
  logic [FW-1:0]    w_fwd_b;
  logic             w_haz_a;
  logic             w_haz_b;
  logic             w_md_busy;
  logic             w_stall;
  logic             w_issue;
  slot_t            w_entry;

  // Slot DEPTH is the WB register; the register file already sees it.
  for (genvar k = 1; k < DEPTH; k++) begin : g_match
    assign w_match_a[k] = i_ra_used && (i_ra != '0) && r_slot[k].valid && r_slot[k].we &&
                          (r_slot[k].rw == SLOT_RW_W'(i_ra));
    assign w_match_b[k] = i_rb_used && (i_rb != '0) && r_slot[k].valid && r_slot[k].we &&
                          (r_slot[k].rw == SLOT_RW_W'(i_rb));
  end

  // Scan oldest to youngest so the youngest producer is the last to win.
  always_comb begin
    w_fwd_a = '0;
    w_fwd_b = '0;
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (w_match_a[k]) begin
        w_fwd_a = FW'(k);
        w_haz_a = (k + 1) < int'(r_slot[k].avail);
      end
      if (w_match_b[k]) begin
        w_fwd_b = FW'(k);
        w_haz_b = (k + 1) < int'(r_slot[k].avail);
      end
    end
  end

  assign w_stall = i_id_valid && !i_flush &&
                   (w_haz_a || w_haz_b || (w_md_busy && (i_is_md || i_rd_hilo)));
  assign w_issue = i_id_valid && !w_stall && !i_flush;

  always_comb begin
    w_entry       = '0;
    w_entry.valid = 1'b1;
    w_entry.we    = i_we;
    w_entry.rw    = SLOT_RW_W'(i_rw);
    w_entry.avail = i_is_load ? SLOT_AV_W'(LOAD_AVAIL) : SLOT_AV_W'(ALU_AVAIL);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        r_slot[k] <= '0;
      end
    end else begin
      r_slot[1] <= w_issue ? w_entry : '0;
      for (int k = 2; k <= DEPTH; k++) begin
        r_slot[k] <= r_slot[k-1];
      end
    end
  end

  md_busy_counter #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_issue && i_is_md),
    .o_busy (w_md_busy)
  );

  assign o_stall   = w_stall;
  assign o_bubble  = w_stall || i_flush;
  assign o_fwd_a   = w_fwd_a;
  assign o_fwd_b   = w_fwd_b;
  assign o_md_busy = w_md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and random stimulus for hazard_scoreboard, checked against a model
// that tracks issued instructions by issue cycle rather than by slot.
module tb_hazard_scoreboard;

  localparam int REG_AW     = 5;
  localparam int DEPTH      = 3;
  localparam int ALU_AVAIL  = 2;
  localparam int LOAD_AVAIL = 3;
  localparam int MD_LAT     = 8;
  localparam int FW         = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid, ra_used, rb_used, we, is_load, is_md, rd_hilo, flush;
  logic [REG_AW-1:0] ra, rb, rw;
  logic              stall, bubble, md_busy;
  logic [FW-1:0]     fwd_a, fwd_b;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_AW     (REG_AW),
    .DEPTH      (DEPTH),
    .ALU_AVAIL  (ALU_AVAIL),
    .LOAD_AVAIL (LOAD_AVAIL),
    .MD_LAT     (MD_LAT)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_id_valid (id_valid),
    .i_ra       (ra),
    .i_rb       (rb),
    .i_ra_used  (ra_used),
    .i_rb_used  (rb_used),
    .i_rw       (rw),
    .i_we       (we),
    .i_is_load  (is_load),
    .i_is_md    (is_md),
    .i_rd_hilo  (rd_hilo),
    .i_flush    (flush),
    .o_stall    (stall),
    .o_bubble   (bubble),
    .o_fwd_a    (fwd_a),
    .o_fwd_b    (fwd_b),
    .o_md_busy  (md_busy)
  );

  typedef struct {
    int cyc;
    int rw;
    bit we;
    bit ld;
  } rec_t;

  rec_t inflight[$];
  int   cyc = 0;
  int   md_cyc = -1000;
  int   checks = 0;
  int   errors = 0;
  bit   e_stall, e_bubble, e_issue, e_busy;
  int   e_fa, e_fb;
  logic obs_stall, obs_bubble, obs_busy;
  logic [FW-1:0] obs_fa, obs_fb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Youngest in-flight writer of r that is still ahead of WB.
  function automatic void operand(input bit used, input int r, output int f, output bit haz);
    int best;
    int best_avail;
    int age;
    best = DEPTH;
    best_avail = 0;
    f = 0;
    haz = 1'b0;
    foreach (inflight[i]) begin
      age = cyc - inflight[i].cyc;
      if (used && r != 0 && inflight[i].we && inflight[i].rw == r &&
          age >= 1 && age < DEPTH && age < best) begin
        best = age;
        best_avail = inflight[i].ld ? LOAD_AVAIL : ALU_AVAIL;
      end
    end
    if (best < DEPTH) begin
      f = best;
      haz = (best + 1) < best_avail;
    end
  endfunction

  function automatic void model();
    bit ha, hb;
    operand(ra_used, int'(ra), e_fa, ha);
    operand(rb_used, int'(rb), e_fb, hb);
    e_busy   = (cyc - md_cyc) >= 1 && (cyc - md_cyc) <= MD_LAT;
    e_stall  = id_valid && !flush && (ha || hb || (e_busy && (is_md || rd_hilo)));
    e_bubble = e_stall || flush;
    e_issue  = id_valid && !e_stall && !flush;
  endfunction

  task automatic drv(input bit v, input int a, input bit au, input int b, input bit bu,
                     input int w, input bit wen, input bit ld, input bit md, input bit hl,
                     input bit fl);
    id_valid = v;
    ra = REG_AW'(a);
    ra_used = au;
    rb = REG_AW'(b);
    rb_used = bu;
    rw = REG_AW'(w);
    we = wen;
    is_load = ld;
    is_md = md;
    rd_hilo = hl;
    flush = fl;
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    if (rst) begin
      inflight.delete();
      md_cyc = -1000;
    end
    model();
    obs_stall = stall;
    obs_bubble = bubble;
    obs_busy = md_busy;
    obs_fa = fwd_a;
    obs_fb = fwd_b;
    chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
    chk({tag, ".bubble"}, 32'(bubble), 32'(e_bubble));
    chk({tag, ".md_busy"}, 32'(md_busy), 32'(e_busy));
    if (e_issue) begin
      chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(e_fa));
      chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(e_fb));
    end
    @(posedge clk);
    if (!rst && e_issue) begin
      inflight.push_back('{cyc: cyc, rw: int'(rw), we: we, ld: is_load});
      if (is_md) md_cyc = cyc;
    end
    cyc++;
    while (inflight.size() > 0 && cyc - inflight[0].cyc > DEPTH) void'(inflight.pop_front());
    #1;
  endtask

  int n;

  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    cycle("rst");
    rst = 1'b0;
    cycle("idle");
    chk("idle.fwd_a", 32'(obs_fa), 0);
    chk("idle.fwd_b", 32'(obs_fb), 0);

    // ALU chain
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    cycle("add_r3");
    drv(1, 3, 1, 0, 0, 7, 1, 0, 0, 0, 0);
    cycle("alu_fwd1");
    chk("alu_fwd1.const", 32'(obs_fa), 1);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    cycle("add_r3b");
    drv(1, 1, 1, 2, 1, 9, 1, 0, 0, 0, 0);
    cycle("unrelated");
    drv(1, 3, 1, 0, 0, 7, 1, 0, 0, 0, 0);
    cycle("alu_fwd2");
    chk("alu_fwd2.const", 32'(obs_fa), 2);

    // Load-use
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    cycle("lw_r5");
    drv(1, 0, 0, 5, 1, 8, 1, 0, 0, 0, 0);
    cycle("lu_stall");
    chk("lu_stall.const", 32'(obs_stall), 1);
    chk("lu_bubble.const", 32'(obs_bubble), 1);
    cycle("lu_go");
    chk("lu_go.stall", 32'(obs_stall), 0);
    chk("lu_go.fwd_b", 32'(obs_fb), 2);
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle("lw_r0");
    drv(1, 0, 0, 0, 1, 8, 1, 0, 0, 0, 0);
    cycle("r0_read");
    chk("r0_read.stall", 32'(obs_stall), 0);
    chk("r0_read.fwd_b", 32'(obs_fb), 0);

    // Priority
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    cycle("add_r4a");
    cycle("add_r4b");
    drv(1, 4, 1, 0, 0, 10, 1, 0, 0, 0, 0);
    cycle("prio");
    chk("prio.const", 32'(obs_fa), 1);
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0);
    cycle("add_r4c");
    drv(1, 0, 0, 0, 0, 11, 0, 0, 0, 0, 0);
    cycle("nowr1");
    cycle("nowr2");
    drv(1, 4, 1, 0, 0, 10, 1, 0, 0, 0, 0);
    cycle("slot3_only");
    chk("slot3_only.const", 32'(obs_fa), 0);

    // Mul/div interlock
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("md_issue");
    drv(1, 0, 0, 0, 0, 2, 1, 0, 0, 1, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle("mflo");
      if (obs_stall) n++;
      else break;
    end
    chk("mflo.stall_len", n, MD_LAT);
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle("md_issue2");
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle("md_again");
      if (obs_stall) n++;
      else break;
    end
    chk("md_again.stall_len", n, MD_LAT);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < MD_LAT + 1; i++) cycle("drain");

    // Flush during load-use stall, with is_md set
    drv(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0);
    cycle("lw_r6");
    drv(1, 6, 1, 0, 0, 12, 1, 0, 1, 0, 0);
    cycle("fl_pre");
    chk("fl_pre.const", 32'(obs_stall), 1);
    flush = 1'b1;
    cycle("flush");
    chk("flush.stall", 32'(obs_stall), 0);
    chk("flush.bubble", 32'(obs_bubble), 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle("post_flush");
    chk("post_flush.md_busy", 32'(obs_busy), 0);

    // Reset in the middle of a load-use stall
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    cycle("lw_r5b");
    drv(1, 0, 0, 5, 1, 8, 1, 0, 0, 0, 0);
    cycle("rst_pre");
    rst = 1'b1;
    cycle("rst_mid");
    chk("rst_mid.stall", 32'(obs_stall), 0);
    rst = 1'b0;
    cycle("rst_after");

    // Random
    for (int i = 0; i < 800; i++) begin
      drv($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Parametrised successor to the fixed two-stage hazard/forwarding unit.
- Sits beside the ID stage and tracks every in-flight register write in a DEPTH-slot shift register: EX = slot 1 … WB = slot DEPTH.
- Each cycle it produces per-operand forwarding selects, load-use stall, flush bubble and a busy interlock for the multi-cycle multiply/divide unit.
- Supports configurable pipeline depth, register-address width and result-availability stages.

## Interface
Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked slots after ID (1 = EX … DEPTH = WB); 2..7.
- ALU_AVAIL, 2, slot index whose pipeline register first holds an ALU result.
- LOAD_AVAIL, 3, same for loads; ALU_AVAIL ≤ LOAD_AVAIL ≤ DEPTH.
- MD_LAT, 8, mul/div busy cycles after issue; ≥1.

Ports (FW = $clog2(DEPTH)):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- ra, rb  in  REG_AW each  ID source registers.
- ra_used, rb_used  in  1 each  source actually read.
- rw  in  REG_AW  ID destination.
- we  in  1  ID writes rw.
- is_load  in  1  ID is a load.
- is_md  in  1  ID starts mul/div.
- rd_hilo  in  1  ID reads HI/LO.
- flush  in  1  branch mispredict: kill ID instruction this cycle.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  insert NOP into EX (= stall | flush).
- fwd_a, fwd_b  out  FW each  0 = register file; k = take slot k+1 register next cycle.
- md_busy  out  1  mul/div counter nonzero.

## Operation
- Slot entry: {valid, we, rw, avail}.
  - avail = LOAD_AVAIL for loads.
  - avail = ALU_AVAIL otherwise.
- Match for operand a at slot k (k < DEPTH): ra_used & ra≠0 & valid_k & we_k & rw_k==ra. Same for b.
- Priority: the lowest matching k (youngest producer) wins; older matches are ignored.
- fwd_a = k of the winning match, else 0. Slot DEPTH is never forwarded; the register file is write-before-read.
- Hazard on a: a winning match with k+1 < avail_k. Same for b.
- stall = id_valid & ~flush & (hazard_a | hazard_b | (md_busy & (is_md | rd_hilo))).
- issue = id_valid & ~stall & ~flush.
- Shift register advances every cycle regardless of stall: slot k+1 ← slot k.
  - Slot 1 ← ID entry if issue.
  - Slot 1 ← invalid otherwise.
- Mul/div counter:
  - issue & is_md loads MD_LAT.
  - Otherwise it decrements when nonzero.
  - md_busy = counter≠0.
- flush overrides stall: stall=0, bubble=1, no slot-1 entry, no counter load.
- All outputs are combinational from state and current inputs. fwd values are meaningful only when issue=1.

## Timing
- Reset (async): all slots invalid, counter 0.
  - With no inputs active: stall=0, bubble=0, fwd_a=fwd_b=0, md_busy=0.
- Deassertion takes effect at the next rising edge.
- Load-use with defaults: producer in slot 1 → stall exactly 1 cycle. Next cycle the producer is in slot 2 and fwd=2 (take slot 3), no stall.
- ALU dependence never stalls with ALU_AVAIL=2.
- md_busy rises the cycle after an md issue and stays high exactly MD_LAT cycles.
  - A dependent md/HI-LO reader issues on the first cycle md_busy=0.
- Reset mid-stall: all tracking is lost. Upstream is reset in the same cycle.

## Structure
- Shared package hazard_pkg holds:
  - Slot-entry struct {valid, we, rw, avail}.
  - Default REG_AW.
  - FW function ($clog2 wrapper).
- One sub-module is natural: md_busy_counter (load, decrement, busy; parameter MD_LAT).
- Match and priority logic is a generate loop over k.

## Test plan
- Reset then idle: all outputs 0. Assert rst mid-sequence → slots cleared within the same cycle.
- ALU chain: add r3 issued, next ID reads ra=r3 → fwd_a=1, stall=0. One cycle later an unrelated instruction, then reader → fwd_a=2.
- Load-use: lw r5, next ID reads rb=r5 → stall=1, bubble=1 for one cycle, then fwd_b=2, stall=0. With rb=r0 → no stall, fwd_b=0.
- Priority: producers r4 in slot 1 and slot 2, reader ra=r4 → fwd_a=1. Producer in slot 3 only → fwd_a=0.
- Mul/div: md issue, then mflo (rd_hilo=1) → stall for 8 cycles, issues on cycle 9. A second md while busy → stalled identically.
- Flush: flush during a load-use stall → stall=0, bubble=1, slot 1 invalid next cycle, counter not loaded even with is_md=1.
